// File: rtl/raster_to_block_buffer_if.sv
`timescale 1ns/1ps
// raster_to_block_buffer_if: raster word input stream and block-row output stream.
// Handshake: a beat transfers on a rising clk edge where valid && ready; once valid is
// raised, the source holds valid and its data/sideband stable until that transfer.
interface raster_to_block_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_row;
  logic        out_block_start;
  logic        out_frame_end;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_block_start, out_frame_end
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_block_start, out_frame_end
  );
endinterface

// File: rtl/raster_to_block_buffer.sv
`timescale 1ns/1ps
// raster_to_block_buffer: reorders raster words into 8x8 block rows using two 8-line stripe banks.
// Build option LEVEL_SHIFT_EN: out_data has every pixel MSB inverted (unsigned p -> signed p-128).
module raster_to_block_buffer #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  raster_to_block_buffer_if.slave  bus
);
  localparam int WPL   = IMG_WIDTH / 8;
  localparam int NSTR  = IMG_HEIGHT / 8;
  localparam int DEPTH = 8 * WPL;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int SW    = (NSTR > 1) ? $clog2(NSTR) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WPL - 1);
  localparam logic [SW-1:0] STR_LAST = SW'(NSTR - 1);

  logic [63:0] bank0 [DEPTH];
  logic [63:0] bank1 [DEPTH];

  // Write side state
  logic [CW-1:0] wcol;
  logic [2:0]    wline;
  logic          wbank;

  // Read side state
  logic [CW-1:0] rblk;
  logic [2:0]    rrow;
  logic [SW-1:0] rstripe;
  logic          rbank;

  logic [1:0]    full;

  logic          wr_fire;
  logic          wr_last;
  logic          rd_fire;
  logic          rd_last;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_word;
  logic [63:0]   out_word;

  assign bus.in_ready  = !reset && !full[wbank];
  assign bus.out_valid = !reset && full[rbank];

  assign wr_fire = bus.in_valid && bus.in_ready;
  assign wr_last = wr_fire && (wline == 3'd7) && (wcol == COL_LAST);
  assign rd_fire = bus.out_valid && bus.out_ready;
  assign rd_last = rd_fire && (rrow == 3'd7) && (rblk == COL_LAST);

  assign wr_addr = AW'(int'(wline) * WPL + int'(wcol));
  assign rd_addr = AW'(int'(rrow) * WPL + int'(rblk));

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wbank) bank1[wr_addr] <= bus.in_data;
      else       bank0[wr_addr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcol  <= '0;
      wline <= '0;
      wbank <= 1'b0;
    end else if (wr_fire) begin
      if (wcol == COL_LAST) begin
        wcol  <= '0;
        wline <= wline + 3'd1;
        if (wline == 3'd7) wbank <= ~wbank;
      end else begin
        wcol <= wcol + CW'(1);
      end
    end
  end

  // Rows advance fastest so each block's 8 rows leave back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrow    <= '0;
      rblk    <= '0;
      rstripe <= '0;
      rbank   <= 1'b0;
    end else if (rd_fire) begin
      rrow <= rrow + 3'd1;
      if (rrow == 3'd7) begin
        if (rblk == COL_LAST) begin
          rblk  <= '0;
          rbank <= ~rbank;
          rstripe <= (rstripe == STR_LAST) ? '0 : rstripe + SW'(1);
        end else begin
          rblk <= rblk + CW'(1);
        end
      end
    end
  end

  // Set and clear never target the same bank: a bank cannot be filling and draining at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
    end else begin
      if (wr_last) full[wbank] <= 1'b1;
      if (rd_last) full[rbank] <= 1'b0;
    end
  end

  assign rd_word = rbank ? bank1[rd_addr] : bank0[rd_addr];

`ifdef LEVEL_SHIFT_EN
  assign out_word = rd_word ^ {8{8'h80}};
`else
  assign out_word = rd_word;
`endif

  assign bus.out_data        = reset ? '0 : out_word;
  assign bus.out_row         = reset ? '0 : rrow;
  assign bus.out_block_start = bus.out_valid && (rrow == 3'd0);
  assign bus.out_frame_end   = bus.out_valid && (rrow == 3'd7) && (rblk == COL_LAST) &&
                               (rstripe == STR_LAST);
endmodule

// File: tb/tb_raster_to_block_buffer.sv
`timescale 1ns/1ps
// tb_raster_to_block_buffer: directed stripes on a 16x16 image, checked by an expected-row queue.
module tb_raster_to_block_buffer;
  localparam int IW   = 16;
  localparam int IH   = 16;
  localparam int WPL  = IW / 8;
  localparam int NSTR = IH / 8;
  localparam int EW   = 69;  // {data[63:0], row[2:0], block_start, frame_end}

  logic clk = 1'b0;
  logic reset;

  raster_to_block_buffer_if bus ();

  raster_to_block_buffer #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            model_stripe = 0;
  int            beats    = 0;
  int            fe_count = 0;
  logic [63:0]   fe_data  = '0;
  logic [63:0]   sw [8][WPL];

  function automatic logic [63:0] shifted(input logic [63:0] d);
`ifdef LEVEL_SHIFT_EN
    return d ^ {8{8'h80}};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    #1;
    if (!reset && bus.out_valid && bus.out_ready) begin
      beats++;
      if (bus.out_frame_end) begin
        fe_count++;
        fe_data = bus.out_data;
      end
      got = {bus.out_data, bus.out_row, bus.out_block_start, bus.out_frame_end};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got data=%h row=%0d with nothing expected",
                 bus.out_data, bus.out_row);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL beat_%0d: got data=%h row=%0d bs=%b fe=%b expected data=%h row=%0d bs=%b fe=%b",
                   beats, got[68:5], got[4:2], got[1], got[0], exp[68:5], exp[4:2], exp[1], exp[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    model_stripe = 0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill_pattern(input int base);
    logic [7:0] b;
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < WPL; c++) begin
        b = 8'(l * 16 + base + c);
        sw[l][c] = {8{b}};
      end
  endtask

  task automatic fill_const(input logic [7:0] even_b, input logic [7:0] odd_b);
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < WPL; c++)
        sw[l][c] = (l % 2 == 0) ? {8{even_b}} : {8{odd_b}};
  endtask

  task automatic push_stripe();
    logic fe;
    for (int blk = 0; blk < WPL; blk++)
      for (int row = 0; row < 8; row++) begin
        fe = (model_stripe == NSTR - 1) && (blk == WPL - 1) && (row == 7);
        exp_q.push_back({shifted(sw[row][blk]), 3'(row), (row == 0), fe});
      end
    model_stripe = (model_stripe + 1) % NSTR;
  endtask

  // Called at a falling edge; returns at the falling edge after the word is taken.
  task automatic send_word(input logic [63:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
      bus.in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_stripe();
    push_stripe();
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < WPL; c++)
        send_word(sw[l][c]);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_queue(input int left, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > left && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > left) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d rows pending, required %0d", exp_q.size(), left);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_in_ready", 64'(bus.in_ready), 64'd0);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    end
    check("reset_out_data", bus.out_data, 64'd0);
    check("reset_out_side", {61'd0, bus.out_block_start, bus.out_frame_end, 1'b0}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_reset_out_valid", 64'(bus.out_valid), 64'd0);

    // Stripe 0, bytes {line,col}
    fill_pattern(0);
    send_stripe();
    wait_queue(0, 100);

    // Back-pressure: two stripes fill both banks, then input stalls
    bus.out_ready = 1'b0;
    fill_pattern(2);
    send_stripe();
    fill_pattern(4);
    send_stripe();
    bus.in_valid = 1'b1;
    bus.in_data  = {8{8'hEE}};
    for (int i = 0; i < 4; i++) begin
      check("both_full_in_ready", 64'(bus.in_ready), 64'd0);
      check("both_full_out_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_queue(16, 100);
    check("in_ready_after_one_drain", 64'(bus.in_ready), 64'd1);
    wait_queue(0, 100);

    // Full frame from a clean start; frame end only on the last row
    do_reset(2);
    fe_count = 0;
    beats    = 0;
    fill_pattern(0);
    send_stripe();
    fill_pattern(8);
    send_stripe();
    wait_queue(0, 200);
    check("frame_beats", 64'(beats), 64'd32);
    check("frame_end_count", 64'(fe_count), 64'd1);
    check("frame_end_data", fe_data, shifted(64'h7979_7979_7979_7979));

    // Reset mid-drain, then reset mid-stripe, then a fresh stripe of 0xAA
    bus.out_ready = 1'b0;
    fill_pattern(1);
    send_stripe();
    repeat (3) @(negedge clk);
    do_reset(1);
    bus.out_ready = 1'b1;
    check("mid_drain_reset_out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 5; i++) send_word({8{8'h55}});
    bus.in_valid = 1'b0;
    do_reset(2);
    beats = 0;
    fill_const(8'hAA, 8'hAA);
    send_stripe();
    wait_queue(0, 100);
    check("fresh_stripe_beats", 64'(beats), 64'd16);

    // Level-shift extremes, with a stall in the middle of the drain
    fill_const(8'h00, 8'hFF);
    bus.out_ready = 1'b0;
    send_stripe();
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b1;
    wait_queue(0, 100);
    repeat (3) @(negedge clk);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
